// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle RV32M multiply (MUL/MULH/MULHSU/MULHU).
// The XLEN x XLEN product is built from four HALF x HALF partial products.
// They are issued one per cycle through a single mulNbits instance and
// shift-accumulated into a 2*XLEN accumulator.

// Half-width multiplier. Each operand is sign- or zero-extended according to
// its signed_mode bit (bit0 = a, bit1 = b). The 2N-bit result is exact for
// every signedness combination.
module mulNbits #(
  parameter int N = 16
) (
  input  logic [1:0]     signed_mode,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);
  logic [2*N-1:0] ax, bx;

  assign ax = {{N{signed_mode[0] & a[N-1]}}, a};
  assign bx = {{N{signed_mode[1] & b[N-1]}}, b};
  // The low 2N bits of the extended product are the true signed/unsigned product
  assign p  = ax * bx;
endmodule

module mul_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);
  localparam int HALF = XLEN / 2;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PP0  = 3'd1,
    S_PP1  = 3'd2,
    S_PP2  = 3'd3,
    S_PP3  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t state, state_next;

  logic [1:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   result_q;

  logic              a_s, b_s;
  logic              accept;
  logic [HALF-1:0]   m_a, m_b;
  logic [1:0]        m_mode;
  logic [XLEN-1:0]   m_prod;
  logic [2*XLEN-1:0] pp_ext, pp_term, acc_sum;

  assign a_s    = (op_q == OP_MULH) || (op_q == OP_MULHSU);
  assign b_s    = (op_q == OP_MULH);
  assign accept = ((state == S_IDLE) || (state == S_DONE)) && start_i && !kill_i;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state: kill wins over everything; MUL skips PP3 since it only
  // contributes above bit XLEN-1
  always_comb begin
    state_next = state;
    if (kill_i) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_next = start_i ? S_PP0 : S_IDLE;
        S_PP0:   state_next = S_PP1;
        S_PP1:   state_next = S_PP2;
        S_PP2:   state_next = (op_q == OP_MUL) ? S_DONE : S_PP3;
        S_PP3:   state_next = S_DONE;
        S_DONE:  state_next = start_i ? S_PP0 : S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    busy_o  = 1'b0;
    valid_o = 1'b0;
    case (state)
      S_PP0, S_PP1, S_PP2, S_PP3: busy_o  = 1'b1;
      S_DONE:                     valid_o = 1'b1;
      default: ;
    endcase
  end

  // Partial-product operand select
  always_comb begin
    m_a    = '0;
    m_b    = '0;
    m_mode = 2'b00;
    case (state)
      S_PP0: begin
        m_a = a_q[HALF-1:0];    m_b = b_q[HALF-1:0];    m_mode = 2'b00;
      end
      S_PP1: begin
        m_a = a_q[HALF-1:0];    m_b = b_q[XLEN-1:HALF]; m_mode = {b_s, 1'b0};
      end
      S_PP2: begin
        m_a = a_q[XLEN-1:HALF]; m_b = b_q[HALF-1:0];    m_mode = {1'b0, a_s};
      end
      S_PP3: begin
        m_a = a_q[XLEN-1:HALF]; m_b = b_q[XLEN-1:HALF]; m_mode = {b_s, a_s};
      end
      default: ;
    endcase
  end

  mulNbits #(.N(HALF)) u_mul (
    .signed_mode (m_mode),
    .a           (m_a),
    .b           (m_b),
    .p           (m_prod)
  );

  // Extend the partial product, weight it by position and add to the accumulator
  always_comb begin
    pp_ext  = {{XLEN{(|m_mode) & m_prod[XLEN-1]}}, m_prod};
    pp_term = '0;
    case (state)
      S_PP0:        pp_term = pp_ext;
      S_PP1, S_PP2: pp_term = pp_ext << HALF;
      S_PP3:        pp_term = pp_ext << XLEN;
      default:      pp_term = '0;
    endcase
    acc_sum = acc + pp_term;
  end

  // Operand latch, accumulator and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q <= op_i;
        a_q  <= rs1_i;
        b_q  <= rs2_i;
        acc  <= '0;
      end else if (busy_o) begin
        acc  <= acc_sum;
      end
      // Final accumulation lands in the result on the same edge DONE is entered
      if (state_next == S_DONE)
        result_q <= (op_q == OP_MUL) ? acc_sum[XLEN-1:0] : acc_sum[2*XLEN-1:XLEN];
    end
  end

  assign result_o = result_q;
endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed corner cases, back-to-back,
// kill, reset mid-operation and random ops against a 64-bit arithmetic model.
module tb_mul_sequencer;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start_i = 1'b0;
  logic [1:0]      op_i = 2'b00;
  logic [XLEN-1:0] rs1_i = '0;
  logic [XLEN-1:0] rs2_i = '0;
  logic            kill_i = 1'b0;
  logic            busy_o, valid_o;
  logic [XLEN-1:0] result_o;

  int checks = 0;
  int errors = 0;

  mul_sequencer #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .kill_i   (kill_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  // Reference: full 64-bit product of the sign/zero-extended operands
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ea, eb;
    logic [63:0] p;
    ea = (op == 2'b01 || op == 2'b10) ? longint'($signed(a)) : longint'({32'b0, a});
    eb = (op == 2'b01) ? longint'($signed(b)) : longint'({32'b0, b});
    p  = 64'(ea * eb);
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_lat(input logic [1:0] op);
    return (op == 2'b00) ? 4 : 5;
  endfunction

  // Issue one op starting at a negedge; returns at the negedge of the DONE
  // cycle (or after the bound). Inputs are scrambled while busy.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_n);
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
    @(posedge clk); #1;
    start_i = 1'b0; op_i = 2'($urandom); rs1_i = $urandom; rs2_i = $urandom;
    lat = -1; busy_n = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (busy_o) busy_n++;
      if (valid_o) begin lat = c; break; end
    end
    res = result_o;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== 32'h0) begin
      errors++;
      $display("FAIL reset: busy=%b valid=%b result=%h, want 0 0 00000000", busy_o, valid_o, result_o);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [1:0]  ops [6] = '{2'b11, 2'b00, 2'b01, 2'b01, 2'b10, 2'b01};
    logic [31:0] as  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [31:0] bs  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] ex  [6] = '{32'hFFFFFFFE, 32'h00000001, 32'h40000000, 32'h00000000, 32'hFFFFFFFF, 32'hC0000000};
    logic [31:0] res;
    int lat, bn;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, bn);
      checks++;
      if (res !== ex[i]) begin
        errors++;
        $display("FAIL directed[%0d] result: got %h want %h", i, res, ex[i]);
      end
      checks++;
      if (lat != exp_lat(ops[i]) || bn != exp_lat(ops[i]) - 1) begin
        errors++;
        $display("FAIL directed[%0d] timing: valid cycle %0d busy %0d, want %0d/%0d",
                 i, lat, bn, exp_lat(ops[i]), exp_lat(ops[i]) - 1);
      end
      @(negedge clk);
      checks++;
      if (valid_o !== 1'b0 || busy_o !== 1'b0 || result_o !== ex[i]) begin
        errors++;
        $display("FAIL directed[%0d] pulse/hold: valid=%b busy=%b result=%h want 0 0 %h",
                 i, valid_o, busy_o, result_o, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r1, r2;
    int l1, l2, b1, b2;
    run_op(2'b00, 32'd3, 32'd5, r1, l1, b1);
    run_op(2'b01, 32'hFFFFFFFE, 32'd7, r2, l2, b2);
    checks++;
    if (r1 !== 32'h0000000F || l1 != 4) begin
      errors++;
      $display("FAIL b2b first: got %h at cycle %0d want 0000000f at 4", r1, l1);
    end
    checks++;
    if (r2 !== 32'hFFFFFFFF || l1 + l2 != 9) begin
      errors++;
      $display("FAIL b2b second: got %h at cycle %0d want ffffffff at 9", r2, l1 + l2);
    end
    @(negedge clk);
  endtask

  task automatic test_kill;
    logic [31:0] prior, res;
    int lat, bn, seen;
    prior = result_o;
    start_i = 1'b1; op_i = 2'b11; rs1_i = 32'h12345678; rs2_i = 32'h9ABCDEF0;
    @(posedge clk); #1;                       // cycle 1
    start_i = 1'b0;
    @(posedge clk); #1;                       // cycle 2
    kill_i = 1'b1; start_i = 1'b1;            // start alongside kill must be ignored
    @(posedge clk); #1;                       // cycle 3
    kill_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== prior) begin
      errors++;
      $display("FAIL kill: busy=%b valid=%b result=%h want 0 0 %h", busy_o, valid_o, result_o, prior);
    end
    seen = 0;
    repeat (6) begin @(negedge clk); if (valid_o || busy_o) seen++; end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL kill_quiet: %0d active cycles after kill, want 0", seen);
    end
    run_op(2'b11, 32'h12345678, 32'h9ABCDEF0, res, lat, bn);
    checks++;
    if (res !== 32'h0B00EA4E || lat != 5) begin
      errors++;
      $display("FAIL kill_retry: got %h at cycle %0d want 0b00ea4e at 5", res, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop;
    logic [31:0] res;
    int lat, bn;
    start_i = 1'b1; op_i = 2'b01; rs1_i = 32'h80000000; rs2_i = 32'h7;
    @(posedge clk); #1; start_i = 1'b0;       // cycle 1 PP0
    @(posedge clk); #1;                       // cycle 2 PP1
    @(posedge clk); #1;                       // cycle 3 PP2
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_midop: busy=%b valid=%b result=%h want 0 0 00000000", busy_o, valid_o, result_o);
    end
    run_op(2'b00, 32'd6, 32'd7, res, lat, bn);
    checks++;
    if (res !== 32'd42 || lat != 4) begin
      errors++;
      $display("FAIL reset_recover: got %h at cycle %0d want 0000002a at 4", res, lat);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h00000000;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    logic [1:0]  op;
    logic [31:0] a, b, res, exp_r;
    int lat, bn, gap;
    for (int n = 0; n < 10000; n++) begin
      op = 2'($urandom); a = pick_operand(); b = pick_operand();
      exp_r = ref_mul(op, a, b);
      run_op(op, a, b, res, lat, bn);
      checks++;
      if (res !== exp_r || lat != exp_lat(op) || bn != exp_lat(op) - 1) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h cyc %0d busy %0d want %h cyc %0d",
                 n, op, a, b, res, lat, bn, exp_r, exp_lat(op));
      end
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        repeat (gap) begin
          @(negedge clk);
          checks++;
          if (valid_o !== 1'b0 || result_o !== exp_r) begin
            errors++;
            $display("FAIL random[%0d] pulse/hold: valid=%b result=%h want 0 %h", n, valid_o, result_o, exp_r);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_kill();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle RV32M multiply unit for the execute stage. It computes MUL, MULH, MULHSU and MULHU by splitting the XLEN×XLEN product into four half-width partial products. It issues them one per cycle to a single `mulNbits` instance (N = XLEN/2) and shift-accumulates the results into a 2·XLEN accumulator. It trades latency for one half-width multiplier instead of a full XLEN×XLEN array.

## Interface
- `XLEN`, default 32: operand width; must be even; the embedded multiplier width is HALF = XLEN/2.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start_i`  in  1  request; sampled only when the unit can accept (IDLE or DONE).
- `op_i`  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0] order); sampled with `start_i`.
- `rs1_i`  in  XLEN  multiplicand; sampled with `start_i`.
- `rs2_i`  in  XLEN  multiplier; sampled with `start_i`.
- `kill_i`  in  1  pipeline flush; aborts any in-flight operation.
- `busy_o`  out  1  high while a partial-product state is active.
- `valid_o`  out  1  one-cycle completion pulse.
- `result_o`  out  XLEN  result; registered, holds until the next completion.

## Operation
- States: IDLE, PP0, PP1, PP2, PP3, DONE.
- Accept:
  - In IDLE or DONE, `start_i`=1 and `kill_i`=0 latches `op_i`, `rs1_i` and `rs2_i`, clears the accumulator and moves to PP0.
  - Otherwise IDLE stays IDLE, and DONE goes to IDLE.
- Signedness:
  - a_s = op is MULH or MULHSU.
  - b_s = op is MULH.
  - MUL uses a_s = b_s = 0; the low word is independent of signedness.
- Partial products. lo/hi are HALF-bit slices of the latched operands; `signed_mode` is given as {bit1 = second-operand sign, bit0 = first-operand sign}.
  - PP0: a_lo × b_lo, mode {0,0}, weight 0.
  - PP1: a_lo × b_hi, mode {b_s,0}, weight HALF.
  - PP2: a_hi × b_lo, mode {0,a_s}, weight HALF.
  - PP3: a_hi × b_hi, mode {b_s,a_s}, weight XLEN.
- Accumulate:
  - Each 2·HALF-bit product is extended to 2·XLEN bits: sign-extended if either of its mode bits is 1, zero-extended otherwise.
  - It is then shifted left by its weight and added to the accumulator modulo 2^(2·XLEN).
- Sequencing:
  - PP0 → PP1 → PP2.
  - PP2 → DONE when op is MUL, because PP3 only touches bits ≥ XLEN.
  - PP2 → PP3 for all other ops; PP3 → DONE.
- Result:
  - On entry to DONE, `result_o` ← acc[XLEN-1:0] for MUL, else acc[2·XLEN-1:XLEN].
  - The result register and `valid_o` are written with the final accumulation in the same edge.
- Kill: `kill_i`=1 in any state → IDLE next cycle. No `valid_o` is produced, `result_o` is unchanged, and a simultaneous `start_i` is ignored.
- `busy_o` = state ∈ {PP0..PP3}.
- `valid_o` = state == DONE.

## Timing
- Reset values: state IDLE, `busy_o` 0, `valid_o` 0, `result_o` 0, accumulator 0, latched op/operands 0.
- Reset mid-operation: reset has priority over `kill_i` and `start_i`; it aborts with no `valid_o`.
- Cycle numbering: cycle 0 is the cycle `start_i` is sampled high.
- Latency:
  - MUL: `busy_o` is high in cycles 1–3 and `valid_o` in cycle 4.
  - MULH, MULHSU and MULHU: `busy_o` is high in cycles 1–4 and `valid_o` in cycle 5.
- Throughput: `start_i` in the DONE cycle is accepted, so a back-to-back MUL issues every 4 cycles and a MULH* every 5.
- While busy, `start_i`, `op_i`, `rs1_i` and `rs2_i` are ignored; the operands need not be held after cycle 0.
- Multiplier path: one half-width multiply plus one 2·XLEN add per cycle, with no combinational path from inputs to outputs.
- `result_o` changes only on the DONE-entry edge or on reset.

## Test plan
- Unsigned all-ones (XLEN=32):
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → `result_o`=0xFFFFFFFE, `valid_o` in cycle 5.
  - MUL on the same operands → 0x00000001, `valid_o` in cycle 4 and `busy_o` high for exactly 3 cycles.
- Signed corner cases:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - MULH 0x7FFFFFFF × 0x80000000 → 0xC0000000.
- Back-to-back: MUL 3×5, with MULH −2×7 presented in the DONE cycle.
  - Expect 0x0000000F at cycle 4, then 0xFFFFFFFF at cycle 9, with no idle cycle between the two operations.
- Kill and hold:
  - Start MULHU 0x12345678 × 0x9ABCDEF0, assert `kill_i` in cycle 2 → IDLE in cycle 3, `valid_o` never asserted, `result_o` keeps its prior value.
  - Then MULHU 0x12345678 × 0x9ABCDEF0 → 0x0B00EA4E.
  - Changing `rs1_i`/`rs2_i` while busy does not alter either result.
- Reset mid-op: assert `reset` in PP2 of a MULH → next cycle `busy_o`=0, `valid_o`=0, `result_o`=0, state IDLE.
- Random: 10k random ops and operands against a 64-bit reference model for all four ops, checking latency and the `valid_o` pulse width (1 cycle).
